// File: rtl/countdown_sched_pkg.sv
// Shared types and constants for the countdown scheduler.
package countdown_sched_pkg;

    // Number of requesters sharing the counter
    localparam int REQ_N = 2;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/load_down_counter.sv
// Loadable down counter.
// Priority is clr, then load, then dec. It saturates at zero.
module load_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next-value selection; decrement is blocked at zero so the count never wraps
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Counter register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/countdown_sched.sv
// Shares one down counter between two requesters.
// It arbitrates, loads the counter and decrements it on tick.
// On reaching zero it pulses done to the owner for one cycle.
// Build option: define COUNTDOWN_SCHED_RR_EN for round-robin tie breaking.
// Without it, requester 0 has fixed priority.
module countdown_sched
    import countdown_sched_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [REQ_N-1:0] req,
    input  logic [WIDTH-1:0] load_val0,
    input  logic [WIDTH-1:0] load_val1,
    input  logic             abort,
    output logic [REQ_N-1:0] gnt,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic [REQ_N-1:0] done
);

    state_t           state_q;
    state_t           state_d;
    logic [REQ_N-1:0] gnt_q;
    logic [REQ_N-1:0] gnt_d;
    logic [REQ_N-1:0] done_q;
    logic [REQ_N-1:0] done_d;
    logic             busy_q;
    logic             busy_d;
    logic             owner_q;
    logic             owner_d;

    logic             ctr_load;
    logic             ctr_dec;
    logic             ctr_clr;
    logic             ctr_zero;
    logic [WIDTH-1:0] ctr_count;
    logic             count_is_one;

    logic             win_idx;
    logic [REQ_N-1:0] win_vec;
    logic [REQ_N-1:0] owner_vec;
    logic [WIDTH-1:0] load_vals [REQ_N];
    logic [WIDTH-1:0] win_load;

    assign load_vals[0] = load_val0;
    assign load_vals[1] = load_val1;
    assign win_load     = load_vals[win_idx];

    // One-hot expansions of the winner and the current owner
    generate
        for (genvar gi = 0; gi < REQ_N; gi++) begin : g_onehot
            assign win_vec[gi]   = (win_idx == 1'(gi));
            assign owner_vec[gi] = (owner_q == 1'(gi));
        end
    endgenerate

`ifdef COUNTDOWN_SCHED_RR_EN
    // Index of the requester granted most recently.
    // It resets to 1 so requester 0 wins the first tie.
    logic last_q;
    logic last_d;

    // Round-robin winner: a tie goes to the requester not granted last
    always_comb begin
        if (&req) begin
            win_idx = ~last_q;
        end else begin
            win_idx = ~req[0];
        end
    end

    // Pointer register, updated on every grant including aborted ones
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed-priority winner: requester 0 wins whenever it asks
    always_comb begin
        win_idx = ~req[0];
    end
`endif

    // Count of 1 about to be decremented ends the interval
    assign count_is_one = !ctr_zero && (ctr_count[WIDTH-1:1] == '0);

    // Next-state, output and counter-control logic
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        busy_d   = busy_q;
        done_d   = '0;
        owner_d  = owner_q;
        ctr_load = 1'b0;
        ctr_dec  = 1'b0;
        ctr_clr  = 1'b0;
`ifdef COUNTDOWN_SCHED_RR_EN
        last_d   = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    owner_d  = win_idx;
                    gnt_d    = win_vec;
                    busy_d   = 1'b1;
                    ctr_load = 1'b1;
`ifdef COUNTDOWN_SCHED_RR_EN
                    last_d   = win_idx;
`endif
                    if (win_load == '0) begin
                        // Zero-length interval completes immediately
                        state_d = ST_DONE;
                        done_d  = win_vec;
                    end else begin
                        state_d = ST_COUNT;
                    end
                end
            end
            ST_COUNT: begin
                if (abort) begin
                    ctr_clr = 1'b1;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (tick) begin
                    ctr_dec = 1'b1;
                    if (count_is_one) begin
                        state_d = ST_DONE;
                        done_d  = owner_vec;
                    end
                end
            end
            ST_DONE: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                ctr_clr = 1'b1;
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
        end
    end

    load_down_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load),
        .load_val (win_load),
        .dec      (ctr_dec),
        .clr      (ctr_clr),
        .count    (ctr_count),
        .zero     (ctr_zero)
    );

    assign gnt   = gnt_q;
    assign busy  = busy_q;
    assign count = ctr_count;
    assign done  = done_q;

endmodule

// File: tb/tb_countdown_sched.sv
// Directed testbench for countdown_sched.
// Inputs change after the falling edge, and outputs are sampled there too.
module tb_countdown_sched;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             tick;
    logic [1:0]       req;
    logic [WIDTH-1:0] load_val0;
    logic [WIDTH-1:0] load_val1;
    logic             abort;
    logic [1:0]       gnt;
    logic             busy;
    logic [WIDTH-1:0] count;
    logic [1:0]       done;

    int errors = 0;
    int checks = 0;

    countdown_sched #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .req       (req),
        .load_val0 (load_val0),
        .load_val1 (load_val1),
        .abort     (abort),
        .gnt       (gnt),
        .busy      (busy),
        .count     (count),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and land on the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 2'b11; tick = 1'b1; abort = 1'b0;
        load_val0 = 4'd3; load_val1 = 4'd4;
        step();
        step();
        checks++;
        if (gnt !== 2'b00 || busy !== 1'b0 || count !== 4'd0 || done !== 2'b00) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b busy=%b count=%0d done=%b, required 00 0 0 00", gnt, busy, count, done);
        end
        req = 2'b00;
        rst = 1'b1;
        step();
        checks++;
        if (gnt !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: gnt=%b busy=%b, required 00 0", gnt, busy);
        end
        $display("test_reset: complete");
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] exp_count;
        req = 2'b01; load_val0 = 4'd3; tick = 1'b1;
        step();
        req = 2'b00;
        for (int k = 0; k < 4; k++) begin
            exp_count = WIDTH'(3 - k);
            checks++;
            if (gnt !== 2'b01 || count !== exp_count || busy !== 1'b1) begin
                errors++;
                $display("FAIL basic_count[%0d]: gnt=%b count=%0d busy=%b, required 01 %0d 1", k, gnt, count, busy, exp_count);
            end
            checks++;
            if (done !== ((k == 3) ? 2'b01 : 2'b00)) begin
                errors++;
                $display("FAIL basic_done[%0d]: done=%b, required %b", k, done, (k == 3) ? 2'b01 : 2'b00);
            end
            if (k < 3) step();
        end
        step();
        checks++;
        if (gnt !== 2'b00 || done !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_release: gnt=%b done=%b busy=%b, required 00 00 0", gnt, done, busy);
        end
        $display("test_basic: grant 01 load 3 finished");
    endtask

    task automatic test_tie();
        logic [1:0] exp_gnt [3];
`ifdef COUNTDOWN_SCHED_RR_EN
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01;
`else
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b01;
`endif
        do_reset();
        load_val0 = 4'd1; load_val1 = 4'd1; tick = 1'b1; req = 2'b11;
        for (int g = 0; g < 3; g++) begin
            step();
            checks++;
            if (gnt !== exp_gnt[g] || count !== 4'd1) begin
                errors++;
                $display("FAIL tie_grant[%0d]: gnt=%b count=%0d, required %b 1", g, gnt, count, exp_gnt[g]);
            end
            if (g == 2) req = 2'b00;
            step();
            checks++;
            if (done !== exp_gnt[g]) begin
                errors++;
                $display("FAIL tie_done[%0d]: done=%b, required %b", g, done, exp_gnt[g]);
            end
            step();
        end
        $display("test_tie: three grants issued");
    endtask

    task automatic test_zero_load();
        req = 2'b10; load_val1 = 4'd0; tick = 1'b1;
        step();
        req = 2'b00;
        checks++;
        if (gnt !== 2'b10 || done !== 2'b10 || busy !== 1'b1 || count !== 4'd0) begin
            errors++;
            $display("FAIL zero_load_grant: gnt=%b done=%b busy=%b count=%0d, required 10 10 1 0", gnt, done, busy, count);
        end
        step();
        checks++;
        if (gnt !== 2'b00 || done !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_load_after: gnt=%b done=%b busy=%b, required 00 00 0", gnt, done, busy);
        end
        $display("test_zero_load: grant 10 load 0 finished");
    endtask

    task automatic test_abort();
        req = 2'b01; load_val0 = 4'd5; tick = 1'b1;
        step();
        req = 2'b00;
        step();
        step();
        checks++;
        if (count !== 4'd3) begin
            errors++;
            $display("FAIL abort_pre: count=%0d, required 3", count);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (count !== 4'd0 || gnt !== 2'b00 || done !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_result: count=%0d gnt=%b done=%b busy=%b, required 0 00 00 0", count, gnt, done, busy);
        end
        step();
        checks++;
        if (done !== 2'b00) begin
            errors++;
            $display("FAIL abort_no_done: done=%b, required 00", done);
        end
        req = 2'b01; load_val0 = 4'd2;
        step();
        req = 2'b00;
        checks++;
        if (gnt !== 2'b01 || count !== 4'd2) begin
            errors++;
            $display("FAIL abort_regrant: gnt=%b count=%0d, required 01 2", gnt, count);
        end
        step();
        step();
        checks++;
        if (done !== 2'b01) begin
            errors++;
            $display("FAIL abort_regrant_done: done=%b, required 01", done);
        end
        step();
        $display("test_abort: aborted at 3 and regranted");
    endtask

    task automatic test_tick_stretch();
        logic [WIDTH-1:0] exp_count;
        req = 2'b01; load_val0 = 4'd2; tick = 1'b0;
        step();
        req = 2'b00;
        for (int k = 1; k <= 6; k++) begin
            tick = (k % 3 == 0);
            step();
            exp_count = (k < 3) ? 4'd2 : ((k < 6) ? 4'd1 : 4'd0);
            checks++;
            if (count !== exp_count || done !== ((k == 6) ? 2'b01 : 2'b00)) begin
                errors++;
                $display("FAIL stretch[%0d]: count=%0d done=%b, required %0d %b", k, count, done, exp_count, (k == 6) ? 2'b01 : 2'b00);
            end
        end
        tick = 1'b0;
        step();
        $display("test_tick_stretch: done six cycles after grant");
    endtask

    task automatic test_max_load();
        req = 2'b10; load_val1 = 4'd15; tick = 1'b1;
        step();
        req = 2'b00;
        for (int k = 0; k <= 15; k++) begin
            checks++;
            if (count !== WIDTH'(15 - k) || done !== ((k == 15) ? 2'b10 : 2'b00)) begin
                errors++;
                $display("FAIL max_load[%0d]: count=%0d done=%b, required %0d %b", k, count, done, 15 - k, (k == 15) ? 2'b10 : 2'b00);
            end
            step();
        end
        checks++;
        if (busy !== 1'b0 || count !== 4'd0) begin
            errors++;
            $display("FAIL max_load_end: busy=%b count=%0d, required 0 0", busy, count);
        end
        $display("test_max_load: grant 10 load 15 finished");
    endtask

    task automatic test_reset_mid();
        req = 2'b01; load_val0 = 4'd7; tick = 1'b0;
        step();
        req = 2'b00;
        checks++;
        if (count !== 4'd7 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: count=%0d busy=%b, required 7 1", count, busy);
        end
        rst = 1'b0;
        step();
        checks++;
        if (gnt !== 2'b00 || busy !== 1'b0 || count !== 4'd0 || done !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid: gnt=%b busy=%b count=%0d done=%b, required 00 0 0 00", gnt, busy, count, done);
        end
        rst = 1'b1; tick = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (done !== 2'b00 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_after[%0d]: done=%b busy=%b, required 00 0", k, done, busy);
            end
        end
        $display("test_reset_mid: interval discarded");
    endtask

    initial begin
        rst = 1'b0; tick = 1'b0; req = 2'b00; abort = 1'b0;
        load_val0 = '0; load_val1 = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_tie();
        test_zero_load();
        test_abort();
        test_tick_stretch();
        test_max_load();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
